serial_subtractor: RTL and testbench

Bit-serial WIDTH-bit subtractor computing DIFF = A − B, LSB first, one bit per clock, through a single full-subtractor cell and a borrow flip-flop. It is the subtraction counterpart of the team's adder cells. It trades latency for area: one 1-bit cell instead of a WIDTH-bit ripple chain. It sits as a standalone arithmetic block behind a simple START/DONE handshake.

---
 rtl/serial_subtractor.sv | 134 +++++++++++++
 tb/tb_serial_subtractor.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial unsigned subtractor: diff = a - b (mod 2^WIDTH), one bit per
//   clock, LSB first, through a single full-subtractor cell and a borrow flop.
//
// Parameters
//   WIDTH      operand/result width, 2..32 (default 8)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      request, accepted only in IDLE or DONE
//   a, b       minuend / subtrahend, captured on the accepting edge only
//   busy       high while shifting (exactly WIDTH cycles per operation)
//   done       one-cycle pulse; result registers were updated on the previous edge
//   diff       (a - b) mod 2^WIDTH of the last completed operation
//   borrow     1 iff a < b (unsigned) for the last completed operation
//   ovf        signed overflow of the last operation (only with SERIAL_SUBTRACTOR_OVF_EN)
//   state_dbg  current FSM state (0 = IDLE, 1 = SHIFT, 2 = DONE)
//
// Handshake: start is a level sampled on each rising edge. It is accepted
// only when the FSM is in IDLE or DONE; a start seen during SHIFT is dropped
// (never queued) and a/b are not sampled. done rises for exactly one cycle
// after the last bit is processed, and diff/borrow/ovf are valid from that
// cycle until the next completion.
//
// Optional feature macro: SERIAL_SUBTRACTOR_OVF_EN adds the ovf port/register.

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  output logic             ovf,
`endif
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sr, b_sr, p_sr;
  logic             br;
  logic [CW-1:0]    cnt;

  logic a0, b0, d, br_next;
  logic load, last;

  // Full-subtractor cell on the current LSBs.
  assign a0      = a_sr[0];
  assign b0      = b_sr[0];
  assign d       = a0 ^ b0 ^ br;
  assign br_next = (~a0 & b0) | (~(a0 ^ b0) & br);

  assign load = start && ((state == S_IDLE) || (state == S_DONE));
  assign last = (state == S_SHIFT) && (cnt == LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_SHIFT;
      S_SHIFT: if (last)  state_nxt = S_DONE;
      S_DONE:  state_nxt = start ? S_SHIFT : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy      = (state == S_SHIFT);
  assign done      = (state == S_DONE);
  assign state_dbg = state;

  // Datapath: operand shift registers, partial difference, borrow, counter,
  // and the result registers that only move on the completion edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      p_sr   <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      borrow <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ovf    <= 1'b0;
`endif
    end else if (load) begin
      a_sr <= a;
      b_sr <= b;
      p_sr <= '0;
      br   <= 1'b0;
      cnt  <= '0;
    end else if (state == S_SHIFT) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      // New bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
      p_sr <= {d, p_sr[WIDTH-1:1]};
      br   <= br_next;
      // Hold at terminal count so the counter never wraps mid-operation.
      cnt  <= last ? cnt : cnt + ONE;
      if (last) begin
        diff   <= {d, p_sr[WIDTH-1:1]};
        borrow <= br_next;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        // Signed overflow: borrow into the MSB differs from borrow out of it.
        ovf    <= br ^ br_next;
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk, rst, start;
  logic [W-1:0] a, b;
  logic         busy, done, borrow;
  logic [W-1:0] diff;
  logic [1:0]   state_dbg;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic         ovf;
`endif

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    .ovf(ovf),
`endif
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [W+1:0] exp_q[$];   // {ovf, borrow, diff}

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] ediff;
    logic         eborrow;
    logic         eovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the operands.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    int ux, uy, sx, sy, sd;
    logic [W-1:0] md;
    logic mb, mo;
    ux = int'(x);
    uy = int'(y);
    sx = (ux >= 128) ? ux - 256 : ux;
    sy = (uy >= 128) ? uy - 256 : uy;
    sd = sx - sy;
    md = W'((ux - uy + 256) % 256);
    mb = (ux < uy);
    mo = (sd > 127) || (sd < -128);
    return {mo, mb, md};
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge: presents start for one edge, returns at the next negedge.
  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1;
    a = x;
    b = y;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom_range(0, 255));
    b = W'($urandom_range(0, 255));
  endtask

  // Waits (bounded) for done; exp_cyc is the number of negedges until done.
  task automatic wait_done(input string name, input int exp_cyc);
    logic [W-1:0] d0;
    logic [W+1:0] e;
    int cyc, nb, both, moved;
    d0 = diff;
    cyc = 0; nb = 0; both = 0; moved = 0;
    while (!done && cyc < 40) begin
      if (busy !== 1'b1) nb++;
      if (diff !== d0) moved++;
      @(negedge clk);
      cyc++;
    end
    if (busy && done) both++;
    chk({name, " latency"}, cyc, exp_cyc);
    chk({name, " busy gaps"}, nb, 0);
    chk({name, " diff held in shift"}, moved, 0);
    chk({name, " done"}, done, 1'b1);
    chk({name, " busy&done"}, both, 0);
    if (exp_q.size() == 0) begin
      chk({name, " scoreboard empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk({name, " diff"}, diff, e[W-1:0]);
      chk({name, " borrow"}, borrow, e[W]);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      chk({name, " ovf"}, ovf, e[W+1]);
`endif
    end
  endtask

  // ---------------- test ----------------
  vec_t tbl[10];

  initial begin
    tbl[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
    tbl[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    tbl[2] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0};
    tbl[3] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    tbl[4] = '{8'h10, 8'h01, 8'h0F, 1'b0, 1'b0};
    tbl[5] = '{8'h09, 8'h04, 8'h05, 1'b0, 1'b0};
    tbl[6] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
    tbl[7] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    tbl[8] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
    tbl[9] = '{8'h80, 8'h00, 8'h80, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    #1;
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset diff", diff, 8'h00);
    chk("reset borrow", borrow, 1'b0);
    chk("reset state", state_dbg, 2'd0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    chk("reset ovf", ovf, 1'b0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed table, idle cycle between operations.
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back({tbl[i].eovf, tbl[i].eborrow, tbl[i].ediff});
      launch(tbl[i].va, tbl[i].vb);
      wait_done($sformatf("tbl%0d", i), W);
      @(negedge clk);
      chk($sformatf("tbl%0d done pulse width", i), done, 1'b0);
      chk($sformatf("tbl%0d idle busy", i), busy, 1'b0);
    end

    // START held through DONE: next op starts with no idle cycle.
    exp_q.push_back({1'b0, 1'b0, 8'h02});
    launch(8'h05, 8'h03);
    wait_done("b2b first", W);
    exp_q.push_back({1'b0, 1'b0, 8'h00});
    launch(8'hFF, 8'hFF);
    wait_done("b2b second", W);
    @(negedge clk);

    // START during SHIFT is ignored.
    exp_q.push_back({1'b0, 1'b0, 8'h05});
    launch(8'h09, 8'h04);
    repeat (2) @(negedge clk);
    start = 1'b1; a = 8'hAA; b = 8'h55;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignored start", W - 3);
    @(negedge clk);
    chk("ignored start no restart", busy, 1'b0);
    chk("ignored start state", state_dbg, 2'd0);

    // Asynchronous reset in the third SHIFT cycle.
    launch(8'h55, 8'h11);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("async rst busy", busy, 1'b0);
    chk("async rst done", done, 1'b0);
    chk("async rst diff", diff, 8'h00);
    chk("async rst borrow", borrow, 1'b0);
    #1 rst = 1'b0;
    begin
      int seen;
      seen = 0;
      repeat (12) begin
        @(negedge clk);
        if (done || busy) seen++;
      end
      chk("no done after abort", seen, 0);
    end

    // First START after reset is accepted immediately.
    exp_q.push_back(model(8'h33, 8'h44));
    launch(8'h33, 8'h44);
    wait_done("post reset", W);

    // Randomized operations, mixing back-to-back and idle gaps.
    for (int i = 0; i < 300; i++) begin
      logic [W-1:0] x, y;
      case ($urandom_range(0, 4))
        0: x = 8'h00;
        1: x = 8'hFF;
        2: x = 8'h80;
        default: x = W'($urandom_range(0, 255));
      endcase
      case ($urandom_range(0, 4))
        0: y = 8'h00;
        1: y = 8'hFF;
        2: y = 8'h7F;
        default: y = W'($urandom_range(0, 255));
      endcase
      exp_q.push_back(model(x, y));
      launch(x, y);
      wait_done($sformatf("rnd%0d a=%0h b=%0h", i, x, y), W);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    chk("scoreboard drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
